// File: rtl/broadcast_pack_pkg.sv
// Shared constants for broadcast_pack: parameter-set derived sizes, FSM encoding and
// the word formatting helper used when BCAST_PACK_BYTE_SWAP_EN is defined.
package broadcast_pack_pkg;

    typedef logic [15:0] pset_t;

    localparam pset_t PSET_L1     = "L1";
    localparam pset_t PSET_L5     = "L5";
    localparam int    TAU_DEFAULT = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Words per alpha (and per beta).
    function automatic int t_for(input pset_t ps);
        return (ps == PSET_L5) ? 4 : 3;
    endfunction

    function automatic int d_split_for(input pset_t ps);
        return (ps == PSET_L1) ? 1 : 2;
    endfunction

    // Entries per signature.
    function automatic int ne_for(input int tau, input int d_split);
        return tau * d_split;
    endfunction

    // Stream words per signature.
    function automatic int nw_for(input int ne, input int t);
        return ne * 2 * t;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/bcast_pingpong_buf.sv
// Two-slot ping-pong store for {beta, alpha} entries; a write may land in the slot
// being released by a pop in the same cycle.
module bcast_pingpong_buf #(
    parameter int W = 256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr_en_i)  wr_ptr_q <= ~wr_ptr_q;
            if (rd_pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({wr_en_i, rd_pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: payload slots carry no reset; occupancy lives in cnt_q, so stale contents are never read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);

endmodule

// File: rtl/broadcast_pack.sv
// Packs broadcast-stage (alpha, beta) entries into a 32-bit ready/valid word stream.
// Define BCAST_PACK_BYTE_SWAP_EN to byte-reverse every output word.
module broadcast_pack
    import broadcast_pack_pkg::*;
#(
    parameter pset_t PARAMETER_SET = PSET_L5,
    parameter int    T             = t_for(PARAMETER_SET),
    parameter int    TAU           = TAU_DEFAULT,
    parameter int    D_SPLIT       = d_split_for(PARAMETER_SET)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_valid,
    input  logic [32*T-1:0] i_alpha,
    input  logic [32*T-1:0] i_beta,
    output logic [31:0]     o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_last,
    output logic            o_busy,
    output logic            o_err,
    output logic            o_done
);

    localparam int NE    = ne_for(TAU, D_SPLIT);
    localparam int WPE   = 2 * T;
    localparam int ENT_W = $clog2(NE + 1);
    localparam int WRD_W = $clog2(WPE);

    state_e           state_q;
    logic [ENT_W-1:0] ent_q;
    logic [WRD_W-1:0] word_q;
    logic             err_q;

    logic [64*T-1:0]  rd_entry;
    logic             buf_full;
    logic             buf_empty;
    logic [31:0]      word_sel;
    logic             last_word;
    logic             xfer;
    logic             pop;
    logic             accept;
    logic             reject;

    assign last_word = (word_q == WRD_W'(WPE - 1));
    assign o_valid   = (state_q == ST_RUN) && !buf_empty;
    assign xfer      = o_valid && i_ready;
    assign pop       = xfer && last_word;

    // With all NE entries captured and a single slot occupied, the read slot holds the final entry.
    assign o_last = o_valid && last_word && !buf_full && (ent_q == ENT_W'(NE));

    assign accept = i_valid && !i_start && (state_q == ST_RUN) &&
                    (ent_q != ENT_W'(NE)) && (!buf_full || pop);
    assign reject = i_valid && !i_start && !accept;

    bcast_pingpong_buf #(
        .W (64 * T)
    ) u_buf (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .flush_i   (i_start),
        .wr_en_i   (accept),
        .wr_data_i ({i_beta, i_alpha}),
        .rd_pop_i  (pop),
        .rd_data_o (rd_entry),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < WPE; i++) begin
            if (word_q == WRD_W'(i)) word_sel = rd_entry[32*i +: 32];
        end
    end

`ifdef BCAST_PACK_BYTE_SWAP_EN
    assign o_data = o_valid ? byte_swap(word_sel) : 32'd0;
`else
    assign o_data = o_valid ? word_sel : 32'd0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            ent_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else if (i_start) begin
            state_q <= ST_RUN;
            ent_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) ent_q <= ent_q + 1'b1;
            if (reject) err_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (xfer) begin
                        word_q <= last_word ? '0 : word_q + 1'b1;
                        if (o_last) state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state_q == ST_RUN);
    assign o_done = (state_q == ST_DONE);
    assign o_err  = err_q;

endmodule

// File: doc/broadcast_pack.md
BROADCAST_PACK -- requirements
Module: broadcast_pack

Interface
- REQ-001 SHALL have parameter PARAMETER_SET, default "L5", selecting the security level ("L1", "L3", "L5").
- REQ-002 SHALL have parameter T, default 4 for "L5" and 3 otherwise, giving the number of 32-bit words per alpha and per beta.
- REQ-003 SHALL have parameter TAU, default 17, giving the number of repetitions.
- REQ-004 SHALL have parameter D_SPLIT, default 1 for "L1" and 2 otherwise, giving the number of splits per repetition.
- REQ-005 SHALL have port i_clk, input, 1 bit, the single clock.
- REQ-006 SHALL have port i_rst, input, 1 bit, an asynchronous active-low reset.
- REQ-007 SHALL have port i_start, input, 1 bit, a one-cycle pulse that begins a new signature.
- REQ-008 SHALL have port i_valid, input, 1 bit, a one-cycle pulse meaning i_alpha/i_beta hold one entry (the upstream broadcast-stage done).
- REQ-009 SHALL have port i_alpha, input, 32*T bits, the alpha words of the entry.
- REQ-010 SHALL have port i_beta, input, 32*T bits, the beta words of the entry.
- REQ-011 SHALL have port o_data, output, 32 bits, the stream word to the hash.
- REQ-012 SHALL have port o_valid, output, 1 bit, meaning o_data is valid.
- REQ-013 SHALL have port i_ready, input, 1 bit, the hash accepting a word.
- REQ-014 SHALL have port o_last, output, 1 bit, marking the final word of the signature.
- REQ-015 SHALL have port o_busy, output, 1 bit, high while the state is RUN.
- REQ-016 SHALL have port o_err, output, 1 bit, a sticky overflow or protocol error flag.
- REQ-017 SHALL have port o_done, output, 1 bit, a one-cycle completion pulse.

Function
- REQ-018 SHALL implement states IDLE, RUN and DONE: IDLE goes to RUN on i_start; RUN goes to DONE on the handshake of the o_last word; DONE goes to IDLE after one cycle, with o_done high in DONE.
- REQ-019 SHALL accept exactly NE = TAU*D_SPLIT entries per signature and stream NW = NE*2*T words in total (L5: 34 entries, 272 words).
- REQ-020 SHALL hold entries in a 2-slot ping-pong buffer, with the write slot captured on the i_valid cycle.
- REQ-021 SHALL assert o_valid for the first word of an entry at the earliest in the cycle after its capture.
- REQ-022 SHALL emit the words of each entry in the order alpha[31:0], alpha[63:32], ..., alpha[32T-1:32T-32], then beta in the same order.
- REQ-023 SHALL treat a transfer as occurring when o_valid and i_ready are both high, and SHALL hold o_data and o_last stable while o_valid is high and i_ready is low.
- REQ-024 SHALL stream back-to-back at one word per cycle when i_ready stays high, including across the boundary between slots.
- REQ-025 SHALL, when i_valid arrives in the same cycle that the last word of the read slot transfers, free that slot and accept the new entry with no error.
- REQ-026 SHALL, when i_valid arrives while both slots are full, drop the entry and set o_err.
- REQ-027 SHALL, when i_valid arrives in IDLE or DONE, or after NE entries have already been captured, ignore the entry and set o_err.
- REQ-028 SHALL assert o_last only with the NW-th word.
- REQ-029 SHALL, on i_start while in RUN or DONE, flush both slots, clear all counters and o_err, and restart in RUN.
- REQ-030 SHALL size the entry counter as CLOG2(NE+1) bits and the word counter as CLOG2(2*T) bits.

Reset
- REQ-031 SHALL, while i_rst is low, asynchronously force state IDLE, empty slots, zeroed counters, and o_data=0, o_valid=0, o_last=0, o_busy=0, o_err=0, o_done=0.
- REQ-032 SHALL, after the reset mid-stream is released, emit no stale words and wait for i_start.

Configuration
- REQ-033 SHALL, with BCAST_PACK_BYTE_SWAP_EN defined, byte-reverse each o_data word ({b0,b1,b2,b3} becomes {b3,b2,b1,b0}) for little-endian hash input.
- REQ-034 SHALL, without BCAST_PACK_BYTE_SWAP_EN, output each word unchanged.

Structure
- REQ-035 SHALL place the PARAMETER_SET-derived T, TAU, D_SPLIT, NE and NW constants, and the state encoding, in the shared sign package.
- REQ-036 SHALL implement the ping-pong storage in one sub-module, bcast_pingpong_buf (2 x 64*T bits, with write and read pointers and full/empty flags).

Verification
- REQ-037 SHALL cover the L5 nominal case: i_start, then 34 entries spaced 40 cycles apart with i_ready=1 -> 272 words in order, o_last on word 272, o_done one cycle later, o_err=0.
- REQ-038 SHALL cover backpressure: i_ready toggling 1,0,0,1 with alpha=32'h0403_0201 -> o_data held stable while i_ready=0, and no word lost or duplicated.
- REQ-039 SHALL cover overflow: i_ready=0 with 3 i_valid pulses -> o_err=1; after i_ready=1, exactly the first two entries (16 words) are emitted.
- REQ-040 SHALL cover the simultaneous case: i_valid in the same cycle as the last-word handshake of a full buffer -> entry accepted and o_err=0.
- REQ-041 SHALL cover reset and restart: i_rst low at word 100 -> all outputs 0 within the same cycle; i_start mid-RUN -> counters clear and the stream restarts from entry 0.
- REQ-042 SHALL cover the macro: with BCAST_PACK_BYTE_SWAP_EN defined, alpha word 32'h0403_0201 -> o_data = 32'h0102_0304.
